// File: rtl/maptable_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : maptable_multi_pkg
//  Description : Shared types and sizes for the N-wide register map table:
//                ROB tag, checkpoint id, instruction layout and map packet.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif
`ifndef NUM_CKPT
`define NUM_CKPT 4
`endif

package maptable_multi_pkg;

    localparam int ROB_TAG_LEN      = `ROB_TAG_LEN;
    localparam int NUM_CKPT_DEFAULT = `NUM_CKPT;
    localparam int CKPT_ID_LEN      = $clog2(NUM_CKPT_DEFAULT);
    localparam int NUM_REGS         = 32;

    // Tag 0 is reserved: the value lives in the architectural regfile.
    typedef logic [ROB_TAG_LEN-1:0] ROB_TAG;
    typedef logic [CKPT_ID_LEN-1:0] CKPT_ID;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } INST_R;

    typedef union packed {
        logic [31:0] raw;
        INST_R       r;
    } INST;

    typedef struct packed {
        ROB_TAG rob_tag_val;
        logic   rob_tag_ready;
    } MAPTABLE_PACKET;

endpackage

`default_nettype wire

// File: rtl/maptable_ckpt_stack.sv
`default_nettype none
// ============================================================================
//  Module      : maptable_ckpt_stack
//  Description : Circular stack of map-table snapshots for mispredict
//                recovery. Keeps head/tail/count and applies CDB wakeups and
//                retirement clears to every stored snapshot each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module maptable_ckpt_stack
    import maptable_multi_pkg::*;
#(
    parameter int NUM_CKPT     = NUM_CKPT_DEFAULT,
    parameter int WB_PORTS     = 2,
    parameter int COMMIT_WIDTH = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        alloc,
    input  ROB_TAG                      snap_map         [NUM_REGS],
    input  logic [NUM_REGS-1:0]         snap_ready,
    input  logic                        recover,
    input  logic [$clog2(NUM_CKPT)-1:0] recover_id,
    input  logic                        ckpt_free,
    input  logic [WB_PORTS-1:0]         valid_wb,
    input  ROB_TAG                      rob_entry_wb     [WB_PORTS],
    input  logic [COMMIT_WIDTH-1:0]     commit,
    input  logic [4:0]                  rd_commit        [COMMIT_WIDTH],
    input  ROB_TAG                      rob_entry_commit [COMMIT_WIDTH],
    output ROB_TAG                      rec_map          [NUM_REGS],
    output logic [NUM_REGS-1:0]         rec_ready,
    output logic [$clog2(NUM_CKPT)-1:0] ckpt_id,
    output logic                        ckpt_full,
    output logic [$clog2(NUM_CKPT):0]   ckpt_count
);

    localparam int ID_W = $clog2(NUM_CKPT);

    ROB_TAG              r_map   [NUM_CKPT][NUM_REGS];
    logic [NUM_REGS-1:0] r_ready [NUM_CKPT];
    logic [ID_W-1:0]     r_head;
    logic [ID_W-1:0]     r_tail;
    logic [ID_W:0]       r_count;

    ROB_TAG              w_cln_map   [NUM_CKPT][NUM_REGS];
    logic [NUM_REGS-1:0] w_cln_ready [NUM_CKPT];
    logic                w_alloc_fire;
    logic                w_free_fire;

    assign ckpt_id      = r_tail;
    assign ckpt_count   = r_count;
    assign ckpt_full    = (r_count == (ID_W+1)'(NUM_CKPT));
    assign w_alloc_fire = alloc && !recover && !ckpt_full;
    assign w_free_fire  = ckpt_free && !recover && (r_count != '0);

    // Raw snapshot selected for recovery; the top applies this cycle's updates.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            rec_map[r] = r_map[recover_id][r];
        end
        rec_ready = r_ready[recover_id];
    end

    // Retirement clear followed by CDB wakeup for every stored snapshot.
    always_comb begin
        for (int n = 0; n < NUM_CKPT; n++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                w_cln_map[n][r]   = r_map[n][r];
                w_cln_ready[n][r] = r_ready[n][r];
                for (int c = 0; c < COMMIT_WIDTH; c++) begin
                    if (commit[c] && rd_commit[c] == 5'(r) &&
                        rob_entry_commit[c] == r_map[n][r]) begin
                        w_cln_map[n][r]   = '0;
                        w_cln_ready[n][r] = 1'b0;
                    end
                end
                for (int w = 0; w < WB_PORTS; w++) begin
                    if (valid_wb[w] && w_cln_map[n][r] != '0 &&
                        rob_entry_wb[w] == w_cln_map[n][r]) begin
                        w_cln_ready[n][r] = 1'b1;
                    end
                end
            end
        end
    end

    // Snapshot storage and circular pointer bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 0; n < NUM_CKPT; n++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    r_map[n][r] <= '0;
                end
                r_ready[n] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int n = 0; n < NUM_CKPT; n++) begin
                r_map[n]   <= w_cln_map[n];
                r_ready[n] <= w_cln_ready[n];
            end
            if (w_alloc_fire) begin
                r_map[r_tail]   <= snap_map;
                r_ready[r_tail] <= snap_ready;
            end
            if (recover) begin
                // Recovered slot and everything younger are released.
                r_tail  <= recover_id;
                r_count <= {1'b0, ID_W'(recover_id - r_head)};
            end else begin
                if (w_alloc_fire) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_free_fire) begin
                    r_head <= r_head + 1'b1;
                end
                case ({w_alloc_fire, w_free_fire})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/maptable_multi.sv
`default_nettype none
// ============================================================================
//  Module      : maptable_multi
//  Description : N-wide register map table. Renames DISPATCH_WIDTH slots per
//                cycle with intra-group bypass, wakes tags from the CDB,
//                clears retired mappings and recovers from checkpoints.
//  Revision    : 1.0 - initial release
// ============================================================================
module maptable_multi
    import maptable_multi_pkg::*;
#(
    parameter int DISPATCH_WIDTH = 2,
    parameter int WB_PORTS       = 2,
    parameter int COMMIT_WIDTH   = 2,
    parameter int NUM_CKPT       = NUM_CKPT_DEFAULT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DISPATCH_WIDTH-1:0]   dispatch_valid,
    input  INST                         inst             [DISPATCH_WIDTH],
    input  logic [4:0]                  rd               [DISPATCH_WIDTH],
    input  ROB_TAG                      rob_entry_in     [DISPATCH_WIDTH],
    input  logic [DISPATCH_WIDTH-1:0]   dispatch_ckpt,
    input  logic [WB_PORTS-1:0]         valid_wb,
    input  logic [4:0]                  rd_wb            [WB_PORTS],
    input  ROB_TAG                      rob_entry_wb     [WB_PORTS],
    input  logic [COMMIT_WIDTH-1:0]     commit,
    input  logic [4:0]                  rd_commit        [COMMIT_WIDTH],
    input  ROB_TAG                      rob_entry_commit [COMMIT_WIDTH],
    input  logic                        recover,
    input  logic [$clog2(NUM_CKPT)-1:0] recover_id,
    input  logic                        ckpt_free,
    output MAPTABLE_PACKET              maptable_packet_rs1 [DISPATCH_WIDTH],
    output MAPTABLE_PACKET              maptable_packet_rs2 [DISPATCH_WIDTH],
    output logic [$clog2(NUM_CKPT)-1:0] ckpt_id,
    output logic                        ckpt_full,
    output logic [$clog2(NUM_CKPT):0]   ckpt_count
);

    ROB_TAG              r_map [NUM_REGS];
    logic [NUM_REGS-1:0] r_ready;

    ROB_TAG              w_rec_map  [NUM_REGS];
    logic [NUM_REGS-1:0] w_rec_ready;
    ROB_TAG              w_base_map [NUM_REGS];
    ROB_TAG              w_cln_map  [NUM_REGS];
    logic [NUM_REGS-1:0] w_cln_ready;
    ROB_TAG              w_next_map [NUM_REGS];
    logic [NUM_REGS-1:0] w_next_ready;
    ROB_TAG              w_snap_map [NUM_REGS];
    logic [NUM_REGS-1:0] w_snap_ready;
    logic                w_alloc_req;
    logic [4:0]          w_src;
    MAPTABLE_PACKET      w_pkt;
    logic                w_unused_bits;

    // Source lookup: youngest earlier slot writing the register wins, else the
    // table entry with same-cycle CDB wakeup. Register 0 never has a producer.
    always_comb begin
        w_src = '0;
        w_pkt = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            maptable_packet_rs1[i] = '0;
            maptable_packet_rs2[i] = '0;
            for (int k = 0; k < 2; k++) begin
                w_src = (k == 0) ? inst[i].r.rs1 : inst[i].r.rs2;
                w_pkt.rob_tag_val   = r_map[w_src];
                w_pkt.rob_tag_ready = r_ready[w_src];
                for (int w = 0; w < WB_PORTS; w++) begin
                    if (valid_wb[w] && r_map[w_src] != '0 &&
                        rob_entry_wb[w] == r_map[w_src]) begin
                        w_pkt.rob_tag_ready = 1'b1;
                    end
                end
                for (int j = 0; j < i; j++) begin
                    if (dispatch_valid[j] && rd[j] == w_src) begin
                        w_pkt.rob_tag_val   = rob_entry_in[j];
                        w_pkt.rob_tag_ready = 1'b0;
                    end
                end
                if (w_src == 5'd0) begin
                    w_pkt = '0;
                end
                if (k == 0) begin
                    maptable_packet_rs1[i] = w_pkt;
                end else begin
                    maptable_packet_rs2[i] = w_pkt;
                end
            end
        end
    end

    // Next table: recovery base, retirement clear, CDB wakeup, then renames.
    // The snapshot copy only sees renames up to and including the branch slot.
    always_comb begin
        w_alloc_req = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_base_map[r]  = recover ? w_rec_map[r] : r_map[r];
            w_cln_map[r]   = w_base_map[r];
            w_cln_ready[r] = recover ? w_rec_ready[r] : r_ready[r];
            for (int c = 0; c < COMMIT_WIDTH; c++) begin
                if (commit[c] && rd_commit[c] == 5'(r) &&
                    rob_entry_commit[c] == w_base_map[r]) begin
                    w_cln_map[r]   = '0;
                    w_cln_ready[r] = 1'b0;
                end
            end
            for (int w = 0; w < WB_PORTS; w++) begin
                if (valid_wb[w] && w_cln_map[r] != '0 &&
                    rob_entry_wb[w] == w_cln_map[r]) begin
                    w_cln_ready[r] = 1'b1;
                end
            end
        end
        w_next_map   = w_cln_map;
        w_next_ready = w_cln_ready;
        w_snap_map   = w_cln_map;
        w_snap_ready = w_cln_ready;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            if (!recover && dispatch_valid[i] && rd[i] != 5'd0) begin
                w_next_map[rd[i]]   = rob_entry_in[i];
                w_next_ready[rd[i]] = 1'b0;
                if (!w_alloc_req) begin
                    w_snap_map[rd[i]]   = rob_entry_in[i];
                    w_snap_ready[rd[i]] = 1'b0;
                end
            end
            if (!recover && dispatch_valid[i] && dispatch_ckpt[i]) begin
                w_alloc_req = 1'b1;
            end
        end
    end

    // Broadcast destination registers and non-source instruction fields are
    // not needed by the table.
    always_comb begin
        w_unused_bits = 1'b0;
        for (int w = 0; w < WB_PORTS; w++) begin
            w_unused_bits = w_unused_bits ^ (^rd_wb[w]);
        end
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            w_unused_bits = w_unused_bits ^ (^inst[i].raw);
        end
    end

    // Architectural-to-tag map and ready bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_map[r] <= '0;
            end
            r_ready <= '0;
        end else begin
            r_map   <= w_next_map;
            r_ready <= w_next_ready;
        end
    end

    maptable_ckpt_stack #(
        .NUM_CKPT     (NUM_CKPT),
        .WB_PORTS     (WB_PORTS),
        .COMMIT_WIDTH (COMMIT_WIDTH)
    ) u_ckpt_stack (
        .clock            (clock),
        .reset            (reset),
        .alloc            (w_alloc_req),
        .snap_map         (w_snap_map),
        .snap_ready       (w_snap_ready),
        .recover          (recover),
        .recover_id       (recover_id),
        .ckpt_free        (ckpt_free),
        .valid_wb         (valid_wb),
        .rob_entry_wb     (rob_entry_wb),
        .commit           (commit),
        .rd_commit        (rd_commit),
        .rob_entry_commit (rob_entry_commit),
        .rec_map          (w_rec_map),
        .rec_ready        (w_rec_ready),
        .ckpt_id          (ckpt_id),
        .ckpt_full        (ckpt_full),
        .ckpt_count       (ckpt_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_maptable_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_maptable_multi
//  Description : Scoreboard bench for maptable_multi: directed scenarios and
//                randomized traffic against a table/queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_maptable_multi;
    import maptable_multi_pkg::*;

    logic            clock = 1'b0;
    logic            reset;
    logic [1:0]      dispatch_valid, dispatch_ckpt, valid_wb, commit;
    INST             inst [2];
    logic [4:0]      rd [2];
    ROB_TAG          rob_entry_in [2];
    logic [4:0]      rd_wb [2];
    ROB_TAG          rob_entry_wb [2];
    logic [4:0]      rd_commit [2];
    ROB_TAG          rob_entry_commit [2];
    logic            recover;
    CKPT_ID          recover_id;
    logic            ckpt_free;
    MAPTABLE_PACKET  pkt_rs1 [2];
    MAPTABLE_PACKET  pkt_rs2 [2];
    CKPT_ID          ckpt_id;
    logic            ckpt_full;
    logic [2:0]      ckpt_count;

    maptable_multi dut (
        .clock(clock), .reset(reset),
        .dispatch_valid(dispatch_valid), .inst(inst), .rd(rd),
        .rob_entry_in(rob_entry_in), .dispatch_ckpt(dispatch_ckpt),
        .valid_wb(valid_wb), .rd_wb(rd_wb), .rob_entry_wb(rob_entry_wb),
        .commit(commit), .rd_commit(rd_commit), .rob_entry_commit(rob_entry_commit),
        .recover(recover), .recover_id(recover_id), .ckpt_free(ckpt_free),
        .maptable_packet_rs1(pkt_rs1), .maptable_packet_rs2(pkt_rs2),
        .ckpt_id(ckpt_id), .ckpt_full(ckpt_full), .ckpt_count(ckpt_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0][5:0] rs1;
        logic [1:0][5:0] rs2;
        logic [1:0]      id;
        logic            full;
        logic [2:0]      cnt;
        logic            has_c1;
        logic            has_c2;
        logic            c_slot;
        logic [5:0]      c_rs1;
        logic [5:0]      c_rs2;
        logic            has_k;
        logic [1:0]      k_id;
        logic            k_full;
        logic [2:0]      k_cnt;
    } exp_t;

    typedef struct packed {
        logic [1:0]       id;
        logic [31:0][4:0] tag;
        logic [31:0]      rdy;
    } ckpt_t;

    exp_t             exp_q[$];
    exp_t             pend;
    exp_t             mon_e;
    logic [31:0][4:0] m_tag;
    logic [31:0]      m_rdy;
    ckpt_t            ck_q[$];
    int               m_head;
    int               checks = 0;
    int               errors = 0;

    // ---------------- reference model ----------------
    function automatic logic [5:0] look(int i, logic [4:0] s);
        logic [4:0] t;
        logic       r;
        if (s == 5'd0) return 6'd0;
        for (int j = i - 1; j >= 0; j--)
            if (dispatch_valid[j] && rd[j] == s) return {rob_entry_in[j], 1'b0};
        t = m_tag[s];
        r = m_rdy[s];
        for (int w = 0; w < 2; w++)
            if (valid_wb[w] && t != 5'd0 && rob_entry_wb[w] == t) r = 1'b1;
        return {t, r};
    endfunction

    function automatic void clean(inout logic [31:0][4:0] t, inout logic [31:0] r);
        for (int x = 0; x < 32; x++) begin
            for (int c = 0; c < 2; c++)
                if (commit[c] && rd_commit[c] == 5'(x) && rob_entry_commit[c] == t[x]) begin
                    t[x] = 5'd0;
                    r[x] = 1'b0;
                end
            for (int w = 0; w < 2; w++)
                if (valid_wb[w] && t[x] != 5'd0 && rob_entry_wb[w] == t[x]) r[x] = 1'b1;
        end
    endfunction

    function automatic void clean_ckpts();
        ckpt_t tmp;
        logic [31:0][4:0] t;
        logic [31:0] r;
        for (int q = 0; q < ck_q.size(); q++) begin
            tmp = ck_q[q];
            t = tmp.tag;
            r = tmp.rdy;
            clean(t, r);
            tmp.tag = t;
            tmp.rdy = r;
            ck_q[q] = tmp;
        end
    endfunction

    task automatic model_step();
        exp_t e;
        ckpt_t nc;
        logic [31:0][4:0] nt, st;
        logic [31:0] nr, sr;
        int sz, tail, k, keep;
        e = '0;
        for (int i = 0; i < 2; i++) begin
            e.rs1[i] = look(i, inst[i].r.rs1);
            e.rs2[i] = look(i, inst[i].r.rs2);
        end
        sz   = ck_q.size();
        tail = (m_head + sz) % 4;
        e.id   = 2'(tail);
        e.full = (sz == 4);
        e.cnt  = 3'(sz);
        e.has_c1 = pend.has_c1; e.has_c2 = pend.has_c2; e.c_slot = pend.c_slot;
        e.c_rs1 = pend.c_rs1; e.c_rs2 = pend.c_rs2;
        e.has_k = pend.has_k; e.k_id = pend.k_id; e.k_full = pend.k_full; e.k_cnt = pend.k_cnt;
        pend = '0;
        exp_q.push_back(e);
        if (reset) begin
            m_tag = '0; m_rdy = '0; ck_q.delete(); m_head = 0;
        end else if (recover) begin
            nt = '0; nr = '0;
            foreach (ck_q[q]) if (ck_q[q].id == recover_id) begin nt = ck_q[q].tag; nr = ck_q[q].rdy; end
            keep = int'(recover_id) - m_head;
            if (keep < 0) keep += 4;
            while (ck_q.size() > keep) void'(ck_q.pop_back());
            clean(nt, nr);
            clean_ckpts();
            m_tag = nt; m_rdy = nr;
        end else begin
            nt = m_tag; nr = m_rdy;
            clean(nt, nr);
            clean_ckpts();
            k = -1;
            for (int i = 0; i < 2; i++) if (dispatch_valid[i] && dispatch_ckpt[i]) k = i;
            if (k >= 0 && sz < 4) begin
                st = nt; sr = nr;
                for (int i = 0; i <= k; i++)
                    if (dispatch_valid[i] && rd[i] != 5'd0) begin st[rd[i]] = rob_entry_in[i]; sr[rd[i]] = 1'b0; end
                nc.id = 2'(tail); nc.tag = st; nc.rdy = sr;
                ck_q.push_back(nc);
            end
            for (int i = 0; i < 2; i++)
                if (dispatch_valid[i] && rd[i] != 5'd0) begin nt[rd[i]] = rob_entry_in[i]; nr[rd[i]] = 1'b0; end
            if (ckpt_free && sz > 0) begin
                void'(ck_q.pop_front());
                m_head = (m_head + 1) % 4;
            end
            m_tag = nt; m_rdy = nr;
        end
    endtask

    // ---------------- monitor ----------------
    task automatic chk(string name, logic [7:0] got, logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rs1_slot%0d", i), {2'b0, pkt_rs1[i]}, {2'b0, mon_e.rs1[i]});
                chk($sformatf("rs2_slot%0d", i), {2'b0, pkt_rs2[i]}, {2'b0, mon_e.rs2[i]});
            end
            chk("ckpt_id", {6'b0, ckpt_id}, {6'b0, mon_e.id});
            chk("ckpt_full", {7'b0, ckpt_full}, {7'b0, mon_e.full});
            chk("ckpt_count", {5'b0, ckpt_count}, {5'b0, mon_e.cnt});
            if (mon_e.has_c1) chk("directed_rs1", {2'b0, pkt_rs1[mon_e.c_slot]}, {2'b0, mon_e.c_rs1});
            if (mon_e.has_c2) chk("directed_rs2", {2'b0, pkt_rs2[mon_e.c_slot]}, {2'b0, mon_e.c_rs2});
            if (mon_e.has_k) begin
                chk("directed_id", {6'b0, ckpt_id}, {6'b0, mon_e.k_id});
                chk("directed_full", {7'b0, ckpt_full}, {7'b0, mon_e.k_full});
                chk("directed_count", {5'b0, ckpt_count}, {5'b0, mon_e.k_cnt});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        dispatch_valid = '0; dispatch_ckpt = '0; valid_wb = '0; commit = '0;
        recover = 1'b0; recover_id = '0; ckpt_free = 1'b0;
        for (int i = 0; i < 2; i++) begin
            inst[i] = '0; rd[i] = '0; rob_entry_in[i] = '0;
            rd_wb[i] = '0; rob_entry_wb[i] = '0; rd_commit[i] = '0; rob_entry_commit[i] = '0;
        end
    endtask

    task automatic do_cycle();
        model_step();
        @(posedge clock);
        #1;
        clear_inputs();
    endtask

    task automatic disp(int s, logic [4:0] d, logic [4:0] t);
        dispatch_valid[s] = 1'b1; rd[s] = d; rob_entry_in[s] = t;
    endtask

    task automatic srcs(int s, logic [4:0] a, logic [4:0] b);
        inst[s].r.rs1 = a; inst[s].r.rs2 = b;
    endtask

    task automatic expc1(int s, logic [4:0] t, logic r);
        pend.has_c1 = 1'b1; pend.c_slot = s[0]; pend.c_rs1 = {t, r};
    endtask

    task automatic expk(logic [1:0] id, logic full, logic [2:0] cnt);
        pend.has_k = 1'b1; pend.k_id = id; pend.k_full = full; pend.k_cnt = cnt;
    endtask

    function automatic logic [4:0] rreg();
        if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        pend = '0;
        m_tag = '0; m_rdy = '0; m_head = 0;
        clear_inputs();
        reset = 1'b1;
        @(posedge clock); @(posedge clock); #1;
        expk(2'd0, 1'b0, 3'd0);
        expc1(0, 5'd0, 1'b0);
        do_cycle();
        reset = 1'b0;

        // intra-group bypass, then table read
        disp(0, 5'd1, 5'd1); disp(1, 5'd2, 5'd2); srcs(1, 5'd1, 5'd0); expc1(1, 5'd1, 1'b0);
        do_cycle();
        srcs(0, 5'd1, 5'd2); expc1(0, 5'd1, 1'b0);
        pend.has_c2 = 1'b1; pend.c_rs2 = {5'd2, 1'b0};
        do_cycle();
        // same-group collision: highest slot wins
        disp(0, 5'd3, 5'd4); disp(1, 5'd3, 5'd5);
        do_cycle();
        srcs(0, 5'd3, 5'd0); expc1(0, 5'd5, 1'b0);
        do_cycle();
        // zero-cycle CDB forwarding
        disp(0, 5'd2, 5'd6);
        do_cycle();
        srcs(0, 5'd2, 5'd0); valid_wb[0] = 1'b1; rob_entry_wb[0] = 5'd6; expc1(0, 5'd6, 1'b1);
        do_cycle();
        srcs(0, 5'd2, 5'd0); expc1(0, 5'd6, 1'b1);
        do_cycle();
        // stale / matching commit, rename beats commit
        disp(0, 5'd1, 5'd5);
        do_cycle();
        commit[0] = 1'b1; rd_commit[0] = 5'd1; rob_entry_commit[0] = 5'd3;
        srcs(0, 5'd1, 5'd0); expc1(0, 5'd5, 1'b0);
        do_cycle();
        commit[0] = 1'b1; rd_commit[0] = 5'd1; rob_entry_commit[0] = 5'd5;
        srcs(0, 5'd1, 5'd0); expc1(0, 5'd5, 1'b0);
        do_cycle();
        srcs(0, 5'd1, 5'd0); expc1(0, 5'd0, 1'b0); disp(0, 5'd1, 5'd5);
        do_cycle();
        disp(0, 5'd1, 5'd7); commit[0] = 1'b1; rd_commit[0] = 5'd1; rob_entry_commit[0] = 5'd5;
        do_cycle();
        srcs(0, 5'd1, 5'd0); expc1(0, 5'd7, 1'b0); expk(2'd0, 1'b0, 3'd0);
        do_cycle();
        // checkpoint, wakeup inside snapshot, recovery
        disp(0, 5'd1, 5'd1); dispatch_ckpt[0] = 1'b1; expk(2'd0, 1'b0, 3'd0);
        do_cycle();
        disp(0, 5'd1, 5'd7); srcs(0, 5'd1, 5'd0); expc1(0, 5'd1, 1'b0); expk(2'd1, 1'b0, 3'd1);
        do_cycle();
        valid_wb[0] = 1'b1; rob_entry_wb[0] = 5'd1; srcs(0, 5'd1, 5'd0); expc1(0, 5'd7, 1'b0);
        do_cycle();
        recover = 1'b1; recover_id = 2'd0; expk(2'd1, 1'b0, 3'd1);
        do_cycle();
        srcs(0, 5'd1, 5'd0); expc1(0, 5'd1, 1'b1); expk(2'd0, 1'b0, 3'd0);
        do_cycle();
        // fill the stack, overflow flag ignored, then release the head
        for (int n = 0; n < 4; n++) begin
            disp(0, 5'd0, 5'd0); dispatch_ckpt[0] = 1'b1;
            do_cycle();
        end
        disp(0, 5'd0, 5'd0); dispatch_ckpt[0] = 1'b1; expk(2'd0, 1'b1, 3'd4);
        do_cycle();
        ckpt_free = 1'b1; expk(2'd0, 1'b1, 3'd4);
        do_cycle();
        expk(2'd0, 1'b0, 3'd3);
        do_cycle();

        // randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) begin
                dispatch_valid[i] = 1'($urandom_range(0, 1));
                inst[i] = $urandom;
                inst[i].r.rs1 = rreg();
                inst[i].r.rs2 = rreg();
                rd[i] = rreg();
                rob_entry_in[i] = 5'($urandom_range(1, 31));
                valid_wb[i] = 1'($urandom_range(0, 1));
                rd_wb[i] = rreg();
                rob_entry_wb[i] = $urandom_range(0, 1) ? m_tag[rreg()] : 5'($urandom_range(0, 31));
                commit[i] = ($urandom_range(0, 2) == 0);
                rd_commit[i] = rreg();
                rob_entry_commit[i] = $urandom_range(0, 1) ? m_tag[rd_commit[i]] : 5'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 2) == 0) begin
                int s;
                s = $urandom_range(0, 1);
                if (dispatch_valid[s]) dispatch_ckpt[s] = 1'b1;
            end
            ckpt_free = ($urandom_range(0, 5) == 0);
            if (ck_q.size() > 0 && $urandom_range(0, 9) == 0) begin
                recover = 1'b1;
                recover_id = ck_q[$urandom_range(0, ck_q.size() - 1)].id;
            end
            do_cycle();
            reset = 1'b0;
        end

        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
